m_gen_bcd_cnt: RTL and testbench



---
 rtl/m_gen_pkg.sv | 50 +++++
 rtl/m_bcd_digit.sv | 35 +++
 rtl/m_gen_bcd_cnt.sv | 119 +++++++++++
 tb/tb_m_gen_bcd_cnt.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/m_gen_pkg.sv
// rtl/m_gen_pkg.sv - shared constants and BCD helper functions for the BCD modulo counter
package m_gen_pkg;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 4;
  localparam int VEC_W      = BCD_W * MAX_DIGITS;

  // Decimal integer to packed BCD, nibble 0 = least significant digit; digits above 'digits' are zero
  function automatic logic [VEC_W-1:0] to_bcd(input int value, input int digits);
    logic [VEC_W-1:0] r;
    int               t;
    r = '0;
    t = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) begin
        r[BCD_W*i +: BCD_W] = BCD_W'(t % 10);
      end
      t = t / 10;
    end
    return r;
  endfunction

  // True when every nibble is a legal decimal digit
  function automatic logic bcd_valid(input logic [VEC_W-1:0] vec);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (vec[BCD_W*i +: BCD_W] > 4'd9) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

  // a <= b on BCD digits, decided by the most significant differing digit
  function automatic logic bcd_le(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
    logic le;
    logic decided;
    le      = 1'b1;
    decided = 1'b0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (!decided && (a[BCD_W*i +: BCD_W] != b[BCD_W*i +: BCD_W])) begin
        le      = (a[BCD_W*i +: BCD_W] < b[BCD_W*i +: BCD_W]);
        decided = 1'b1;
      end
    end
    return le;
  endfunction

endpackage

// File: rtl/m_bcd_digit.sv
// rtl/m_bcd_digit.sv - single BCD digit increment/decrement step with ripple out
module m_bcd_digit
  import m_gen_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  input  logic             step_in,
  input  logic             up,
  output logic [BCD_W-1:0] d_next,
  output logic             step_out
);

  // Step this digit when the lower digits ripple into it; 9->0 up and 0->9 down ripple onward
  always_comb begin
    d_next   = d;
    step_out = 1'b0;
    if (step_in) begin
      if (up) begin
        if (d == 4'd9) begin
          d_next   = 4'd0;
          step_out = 1'b1;
        end else begin
          d_next = d + 4'd1;
        end
      end else begin
        if (d == 4'd0) begin
          d_next   = 4'd9;
          step_out = 1'b1;
        end else begin
          d_next = d - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/m_gen_bcd_cnt.sv
// rtl/m_gen_bcd_cnt.sv - parametrised N-digit BCD modulo counter with preset and carry/borrow pulses
module m_gen_bcd_cnt
  import m_gen_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  sat,
  input  logic                  load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                  carry,
  output logic                  borrow,
  output logic                  load_err,
  output logic                  at_max,
  output logic                  at_min
);

  localparam int W = BCD_W * DIGITS;

  if ((DIGITS < 1) || (DIGITS > MAX_DIGITS) || (MIN_VAL < 0) ||
      (MIN_VAL > MAX_VAL) || (MAX_VAL >= 10**DIGITS)) begin : g_bad_params
    $error("m_gen_bcd_cnt: need 1<=DIGITS<=4 and 0<=MIN_VAL<=MAX_VAL<10**DIGITS");
  end

  localparam logic [VEC_W-1:0] MIN_VEC = to_bcd(MIN_VAL, DIGITS);
  localparam logic [VEC_W-1:0] MAX_VEC = to_bcd(MAX_VAL, DIGITS);
  localparam logic [W-1:0]     MIN_BCD = MIN_VEC[W-1:0];
  localparam logic [W-1:0]     MAX_BCD = MAX_VEC[W-1:0];

  logic [W-1:0]    cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            borrow_q, borrow_d;
  logic            load_err_q, load_err_d;

  logic [W-1:0]    stepped;
  logic [DIGITS:0] step;
  logic            at_max_w;
  logic            at_min_w;
  logic            hit_bound;
  logic            load_ok;

  // Ripple chain of digit step units; the least significant digit always steps
  assign step[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    m_bcd_digit u_digit (
      .d        (cnt_q[BCD_W*g +: BCD_W]),
      .step_in  (step[g]),
      .up       (up_dn),
      .d_next   (stepped[BCD_W*g +: BCD_W]),
      .step_out (step[g+1])
    );
  end

  assign at_max_w = (cnt_q == MAX_BCD);
  assign at_min_w = (cnt_q == MIN_BCD);

  // A ripple out of the top digit can only coincide with a bound, so it is treated as one
  assign hit_bound = step[DIGITS] | (up_dn ? at_max_w : at_min_w);

  assign load_ok = bcd_valid(VEC_W'(load_val)) &&
                   bcd_le(MIN_VEC, VEC_W'(load_val)) &&
                   bcd_le(VEC_W'(load_val), MAX_VEC);

  // Next count and pulses: load beats en; pulses default low every cycle
  always_comb begin
    cnt_d      = cnt_q;
    carry_d    = 1'b0;
    borrow_d   = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        cnt_d = load_val;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (!hit_bound) begin
        cnt_d = stepped;
      end else if (!sat) begin
        if (up_dn) begin
          cnt_d   = MIN_BCD;
          carry_d = 1'b1;
        end else begin
          cnt_d    = MAX_BCD;
          borrow_d = 1'b1;
        end
      end
    end
  end

  // State registers; reset overrides load and en on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= MIN_BCD;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
      load_err_q <= load_err_d;
    end
  end

  assign bcd      = cnt_q;
  assign carry    = carry_q;
  assign borrow   = borrow_q;
  assign load_err = load_err_q;
  assign at_max   = at_max_w;
  assign at_min   = at_min_w;

endmodule

// File: tb/tb_m_gen_bcd_cnt.sv
// tb/tb_m_gen_bcd_cnt.sv - scoreboard testbench for the BCD modulo counter
module tb_m_gen_bcd_cnt;

  logic        clk;
  logic        rst;
  logic        en;
  logic        up_dn;
  logic        sat;
  logic        load;
  logic [11:0] load_val;

  logic [7:0]  bcd0, bcd1;
  logic [11:0] bcd2;
  logic        c0, b0, le0, mx0, mn0;
  logic        c1, b1, le1, mx1, mn1;
  logic        c2, b2, le2, mx2, mn2;

  typedef struct {
    int          id;
    int          seq;
    logic [11:0] bcd;
    logic        c;
    logic        b;
    logic        le;
    logic        amax;
    logic        amin;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   seq   = 0;
  int   minv[3] = '{0, 1, 0};
  int   maxv[3] = '{23, 12, 365};

  m_gen_bcd_cnt u_dut0 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat), .load(load),
    .load_val(load_val[7:0]), .bcd(bcd0), .carry(c0), .borrow(b0),
    .load_err(le0), .at_max(mx0), .at_min(mn0)
  );

  m_gen_bcd_cnt #(.DIGITS(2), .MIN_VAL(1), .MAX_VAL(12)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat), .load(load),
    .load_val(load_val[7:0]), .bcd(bcd1), .carry(c1), .borrow(b1),
    .load_err(le1), .at_max(mx1), .at_min(mn1)
  );

  m_gen_bcd_cnt #(.DIGITS(3), .MIN_VAL(0), .MAX_VAL(365)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat), .load(load),
    .load_val(load_val), .bcd(bcd2), .carry(c2), .borrow(b2),
    .load_err(le2), .at_max(mx2), .at_min(mn2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] tobcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Drive one cycle of inputs and queue the response expected after the next edge
  task automatic cyc(input int id, input bit r, input bit e, input bit u, input bit s,
                     input bit l, input logic [11:0] v, input int ev,
                     input bit ec, input bit eb, input bit ele);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; up_dn = u; sat = s; load = l; load_val = v;
    x.id   = id;
    x.seq  = seq;
    x.bcd  = tobcd(ev);
    x.c    = ec;
    x.b    = eb;
    x.le   = ele;
    x.amax = (ev == maxv[id]);
    x.amin = (ev == minv[id]);
    sb.push_back(x);
    seq++;
  endtask

  // Monitor: one response per edge, compared against the oldest queued expectation
  exp_t        mx;
  logic [11:0] a_bcd;
  logic        a_c, a_b, a_le, a_mx, a_mn;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mx = sb.pop_front();
      case (mx.id)
        0:       begin a_bcd = {4'd0, bcd0}; a_c = c0; a_b = b0; a_le = le0; a_mx = mx0; a_mn = mn0; end
        1:       begin a_bcd = {4'd0, bcd1}; a_c = c1; a_b = b1; a_le = le1; a_mx = mx1; a_mn = mn1; end
        default: begin a_bcd = bcd2;         a_c = c2; a_b = b2; a_le = le2; a_mx = mx2; a_mn = mn2; end
      endcase
      n_cmp++;
      if (a_bcd !== mx.bcd || a_c !== mx.c || a_b !== mx.b || a_le !== mx.le ||
          a_mx !== mx.amax || a_mn !== mx.amin) begin
        n_bad++;
        $display("FAIL step%0d dut%0d: got bcd=%h carry=%b borrow=%b load_err=%b at_max=%b at_min=%b, expected bcd=%h carry=%b borrow=%b load_err=%b at_max=%b at_min=%b",
                 mx.seq, mx.id, a_bcd, a_c, a_b, a_le, a_mx, a_mn,
                 mx.bcd, mx.c, mx.b, mx.le, mx.amax, mx.amin);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; sat = 1'b0; load = 1'b0; load_val = '0;

    // Default 00..23 dial: reset, then 24 up steps wrapping to 00 with one carry
    cyc(0, 1, 0, 1, 0, 0, 12'h000, 0, 0, 0, 0);
    for (int i = 1; i <= 24; i++) cyc(0, 0, 1, 1, 0, 0, 12'h000, i % 24, (i == 24), 0, 0);

    // Saturate at MAX going up, then at MIN going down
    cyc(0, 0, 0, 1, 1, 1, 12'h023, 23, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 1, 0, 12'h000, 23, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 12'h000, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 1, 0, 12'h000, 0, 0, 0, 0);

    // Down from 10 through 00 and wrap to 23 with one borrow
    cyc(0, 0, 0, 0, 0, 1, 12'h010, 10, 0, 0, 0);
    for (int i = 1; i <= 11; i++)
      cyc(0, 0, 1, 0, 0, 0, 12'h000, (i == 11) ? 23 : 10 - i, 0, (i == 11), 0);

    // Presets: non-BCD nibble, out of range, then a good one
    cyc(0, 0, 0, 1, 0, 1, 12'h01A, 23, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 12'h000, 23, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 1, 12'h024, 23, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1, 12'h017, 17, 0, 0, 0);

    // Load beats en; reset beats a pending carry; gated en steps only when high
    cyc(0, 0, 1, 1, 0, 1, 12'h005, 5, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 1, 12'h023, 23, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0, 12'h000, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 12'h000, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 12'h000, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 12'h000, 2, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 12'h000, 2, 0, 0, 0);

    // 12-hour dial 01..12
    cyc(1, 1, 0, 1, 0, 0, 12'h000, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 1, 12'h012, 12, 0, 0, 0);
    cyc(1, 0, 1, 1, 0, 0, 12'h000, 1, 1, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 12'h000, 12, 0, 1, 0);
    cyc(1, 0, 1, 0, 0, 0, 12'h000, 11, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 1, 12'h000, 11, 0, 0, 1);
    cyc(1, 0, 0, 1, 0, 1, 12'h013, 11, 0, 0, 1);

    // Three-digit day counter 000..365
    cyc(2, 1, 0, 1, 0, 0, 12'h000, 0, 0, 0, 0);
    cyc(2, 0, 0, 1, 0, 1, 12'h099, 99, 0, 0, 0);
    cyc(2, 0, 1, 1, 0, 0, 12'h000, 100, 0, 0, 0);
    cyc(2, 0, 1, 0, 0, 0, 12'h000, 99, 0, 0, 0);
    cyc(2, 0, 0, 1, 0, 1, 12'h365, 365, 0, 0, 0);
    cyc(2, 0, 1, 1, 0, 0, 12'h000, 0, 1, 0, 0);
    cyc(2, 0, 1, 0, 0, 0, 12'h000, 365, 0, 1, 0);
    cyc(2, 0, 0, 1, 0, 1, 12'h366, 365, 0, 0, 1);

    @(negedge clk);
    en = 1'b0; load = 1'b0;
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d responses still pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
